// File: rtl/ro_pkg.sv
// Shared constants and state encoding for the row readout sequencer.
package ro_pkg;

    localparam int unsigned NUM_ROW       = 320;
    localparam int unsigned ROW_W         = 9;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned STALL_TIMEOUT = 65535;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHR,
        SHS,
        CONV,
        WAIT_FIFO,
        NEXT,
        DONE
    } ro_state_t;

endpackage

// File: rtl/ro_phase_timer.sv
// Loadable phase down-counter; a zero duration is stretched to one cycle.
// done is registered and is high on the final cycle of the loaded duration.
module ro_phase_timer #(
    parameter int unsigned CNT_W = ro_pkg::CNT_W
) (
    input  logic             CLKM,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    import ro_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ld_val_c;

    assign ld_val_c = (load_val == '0) ? CNT_W'(1) : load_val;

    always_ff @(posedge CLKM) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= ld_val_c;
            done <= (ld_val_c == CNT_W'(1));
        end else if (cnt > CNT_W'(1)) begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(2));
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Row-by-row readout controller: strobes every row, hands rows to the FIFO.
// Optional stall timeout in WAIT_FIFO enabled by RO_STALL_TIMEOUT_EN.
module readout_sequencer #(
    parameter int unsigned NUM_ROW = ro_pkg::NUM_ROW,
    parameter int unsigned ROW_W   = ro_pkg::ROW_W,
    parameter int unsigned CNT_W   = ro_pkg::CNT_W
) (
    input  logic             CLKM,
    input  logic             rst,
    input  logic             trigger_i,
    output logic             re_busy,
    input  logic [CNT_W-1:0] Tsel,
    input  logic [CNT_W-1:0] Tsh,
    input  logic [CNT_W-1:0] Tconv,
    input  logic             fifo_ready,
    output logic             row_valid,
    output logic [ROW_W-1:0] ROWADD_RO,
    output logic             PIXSEL,
    output logic             SH_RST,
    output logic             SH_SIG,
    output logic             ADC_CONV,
    output logic [31:0]      frame_cnt,
    output logic             overflow
);
    import ro_pkg::*;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW - 1);

    ro_state_t        state;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;
    logic             tmr_done;
    logic             last_row_c;

`ifdef RO_STALL_TIMEOUT_EN
    logic [15:0]      stall_cnt;
`endif

    assign last_row_c = (ROWADD_RO == LAST_ROW);

    ro_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .CLKM     (CLKM),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done     (tmr_done)
    );

    // Durations are sampled only on the edge that enters a timed phase.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = Tsel;
        case (state)
            IDLE: tmr_load_c = trigger_i;
            SEL:  begin tmr_load_c = tmr_done; tmr_val_c = Tsh;   end
            SHR:  begin tmr_load_c = tmr_done; tmr_val_c = Tsh;   end
            SHS:  begin tmr_load_c = tmr_done; tmr_val_c = Tconv; end
            NEXT: tmr_load_c = !last_row_c;
            default: ;
        endcase
    end

    // Strobes are driven from the edge that enters each state, so all are registered.
    always_ff @(posedge CLKM) begin
        if (rst) begin
            state     <= IDLE;
            re_busy   <= 1'b0;
            row_valid <= 1'b0;
            ROWADD_RO <= '0;
            PIXSEL    <= 1'b0;
            SH_RST    <= 1'b0;
            SH_SIG    <= 1'b0;
            ADC_CONV  <= 1'b0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
`ifdef RO_STALL_TIMEOUT_EN
            stall_cnt <= '0;
`endif
        end else begin
            row_valid <= 1'b0;
            case (state)
                IDLE: if (trigger_i) begin
                    state     <= SEL;
                    re_busy   <= 1'b1;
                    PIXSEL    <= 1'b1;
                    ROWADD_RO <= '0;
                end
                SEL: if (tmr_done) begin
                    state  <= SHR;
                    SH_RST <= 1'b1;
                end
                SHR: if (tmr_done) begin
                    state  <= SHS;
                    SH_RST <= 1'b0;
                    SH_SIG <= 1'b1;
                end
                SHS: if (tmr_done) begin
                    state    <= CONV;
                    SH_SIG   <= 1'b0;
                    PIXSEL   <= 1'b0;
                    ADC_CONV <= 1'b1;
                end
                CONV: if (tmr_done) begin
                    state    <= WAIT_FIFO;
                    ADC_CONV <= 1'b0;
`ifdef RO_STALL_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                end
                WAIT_FIFO: begin
                    if (fifo_ready) begin
                        state     <= NEXT;
                        row_valid <= 1'b1;
                    end
`ifdef RO_STALL_TIMEOUT_EN
                    else if (stall_cnt == 16'(STALL_TIMEOUT - 1)) begin
                        state    <= NEXT;
                        overflow <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
`endif
                end
                NEXT: begin
                    if (last_row_c) begin
                        state     <= DONE;
                        re_busy   <= 1'b0;
                        frame_cnt <= frame_cnt + 32'd1;
                    end else begin
                        state     <= SEL;
                        PIXSEL    <= 1'b1;
                        ROWADD_RO <= ROWADD_RO + ROW_W'(1);
                    end
                end
                DONE: if (!trigger_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer (NUM_ROW=4): expected row handoffs are queued
// at launch and checked by a monitor on every row_valid.
`timescale 1ns/100ps
module tb_readout_sequencer;

    localparam int unsigned NR    = 4;
    localparam int unsigned ROW_W = 9;
    localparam int unsigned CNT_W = 16;

    logic             CLKM = 1'b0;
    logic             rst = 1'b1;
    logic             trigger_i = 1'b0;
    logic             fifo_ready = 1'b1;
    logic [CNT_W-1:0] Tsel = '0;
    logic [CNT_W-1:0] Tsh = '0;
    logic [CNT_W-1:0] Tconv = '0;
    logic             re_busy, row_valid, PIXSEL, SH_RST, SH_SIG, ADC_CONV, overflow;
    logic [ROW_W-1:0] ROWADD_RO;
    logic [31:0]      frame_cnt;

    readout_sequencer #(.NUM_ROW(NR), .ROW_W(ROW_W), .CNT_W(CNT_W)) dut (
        .CLKM(CLKM), .rst(rst), .trigger_i(trigger_i), .re_busy(re_busy),
        .Tsel(Tsel), .Tsh(Tsh), .Tconv(Tconv), .fifo_ready(fifo_ready),
        .row_valid(row_valid), .ROWADD_RO(ROWADD_RO), .PIXSEL(PIXSEL),
        .SH_RST(SH_RST), .SH_SIG(SH_SIG), .ADC_CONV(ADC_CONV),
        .frame_cnt(frame_cnt), .overflow(overflow)
    );

    always #2.5 CLKM = ~CLKM;

    int cyc = 0;
    always @(posedge CLKM) cyc <= cyc + 1;

    typedef struct { int row; int cyc; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_row(input int row, input int c);
        exp_t e;
        e.row = row;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Advance to just after the posedge that makes cyc == t.
    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge CLKM);
            #1;
        end
    endtask

    task automatic launch(input int a, input int b, input int c, output int n);
        Tsel      = CNT_W'(a);
        Tsh       = CNT_W'(b);
        Tconv     = CNT_W'(c);
        trigger_i = 1'b1;
        n         = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_re_busy"},   re_busy,   0);
        chk({tag, "_row_valid"}, row_valid, 0);
        chk({tag, "_rowadd"},    ROWADD_RO, 0);
        chk({tag, "_pixsel"},    PIXSEL,    0);
        chk({tag, "_sh_rst"},    SH_RST,    0);
        chk({tag, "_sh_sig"},    SH_SIG,    0);
        chk({tag, "_adc_conv"},  ADC_CONV,  0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_overflow"},  overflow,  0);
    endtask

    // Phase strobes of one row whose SEL starts at cycle base (a,b,c already clamped).
    task automatic check_phases(input int base, input int a, input int b, input int c, input int row);
        wait_until(base);
        chk("sel_pixsel", PIXSEL, 1);
        chk("sel_sh_rst", SH_RST, 0);
        chk("sel_row",    ROWADD_RO, row);
        wait_until(base + a);
        chk("shr_sh_rst", SH_RST, 1);
        chk("shr_pixsel", PIXSEL, 1);
        wait_until(base + a + b);
        chk("shs_sh_sig", SH_SIG, 1);
        chk("shs_sh_rst", SH_RST, 0);
        wait_until(base + a + 2 * b);
        chk("conv_adc",    ADC_CONV, 1);
        chk("conv_pixsel", PIXSEL, 0);
        wait_until(base + a + 2 * b + c);
        chk("wait_adc", ADC_CONV, 0);
        chk("wait_row", ROWADD_RO, row);
    endtask

    // Monitor: every row handoff must match the head of the scoreboard.
    always @(negedge CLKM) begin
        if (!rst) begin
            if (SH_RST && SH_SIG) begin
                checks++;
                fails++;
                $display("FAIL sh_exclusive @cyc %0d: SH_RST and SH_SIG both 1, required not both", cyc);
            end
            if (row_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_row_valid @cyc %0d: row %0d, expected none", cyc, ROWADD_RO);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("row_addr", ROWADD_RO, e.row);
                    chk("row_cyc",  cyc,       e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;

        // Reset state
        wait_until(3);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic frame: P = 4+2*3+5+2 = 17
        p = 17;
        wait_until(10);
        launch(4, 3, 5, n);
        for (int r = 0; r < int'(NR); r++) push_row(r, n + (r + 1) * p);
        wait_until(n + 1);
        chk("basic_busy_rise", re_busy, 1);
        chk("basic_pixsel_rise", PIXSEL, 1);
        trigger_i = 1'b0;
        check_phases(n + 1, 4, 3, 5, 0);
        check_phases(n + p + 1, 4, 3, 5, 1);
        wait_until(n + 4 * p);
        chk("basic_busy_last_next", re_busy, 1);
        wait_until(n + 4 * p + 1);
        chk("basic_busy_fall", re_busy, 0);
        chk("basic_frame_cnt", frame_cnt, 1);
        chk("basic_overflow", overflow, 0);

        // Zero durations: each phase 1 cycle, P = 6
        p = 6;
        wait_until(cyc + 3);
        launch(0, 0, 0, n);
        for (int r = 0; r < int'(NR); r++) push_row(r, n + (r + 1) * p);
        wait_until(n + 1);
        chk("zero_busy_rise", re_busy, 1);
        trigger_i = 1'b0;
        check_phases(n + 1, 1, 1, 1, 0);
        wait_until(n + 4 * p + 1);
        chk("zero_busy_fall", re_busy, 0);
        chk("zero_frame_cnt", frame_cnt, 2);

        // Backpressure: row 1 held 50 cycles in WAIT_FIFO
        p = 17;
        wait_until(cyc + 3);
        launch(4, 3, 5, n);
        push_row(0, n + p);
        for (int r = 1; r < int'(NR); r++) push_row(r, n + (r + 1) * p + 50);
        wait_until(n + 1);
        trigger_i = 1'b0;
        wait_until(n + 2 * p - 1);
        fifo_ready = 1'b0;
        wait_until(n + 2 * p + 49);
        chk("bp_still_busy", re_busy, 1);
        chk("bp_row_held", ROWADD_RO, 1);
        fifo_ready = 1'b1;
        wait_until(n + 4 * p + 51);
        chk("bp_busy_fall", re_busy, 0);
        chk("bp_frame_cnt", frame_cnt, 3);
        chk("bp_overflow", overflow, 0);

        // Held trigger: no relaunch until trigger falls and rises again
        p = 6;
        wait_until(cyc + 3);
        launch(0, 0, 0, n);
        for (int r = 0; r < int'(NR); r++) push_row(r, n + (r + 1) * p);
        wait_until(n + 4 * p + 1);
        chk("held_busy_fall", re_busy, 0);
        wait_until(n + 40);
        chk("held_busy_low", re_busy, 0);
        chk("held_pixsel_low", PIXSEL, 0);
        chk("held_frame_cnt", frame_cnt, 4);
        trigger_i = 1'b0;
        wait_until(n + 43);
        chk("held_idle_busy", re_busy, 0);
        launch(0, 0, 0, n);
        for (int r = 0; r < int'(NR); r++) push_row(r, n + (r + 1) * p);
        wait_until(n + 1);
        chk("relaunch_busy", re_busy, 1);
        trigger_i = 1'b0;
        wait_until(n + 4 * p + 1);
        chk("relaunch_frame_cnt", frame_cnt, 5);

        // Reset mid-frame during SHS of row 2 (frame_cnt cleared first)
        p = 17;
        rst = 1'b1;
        wait_until(cyc + 2);
        rst = 1'b0;
        chk("pre_mid_frame_cnt", frame_cnt, 0);
        wait_until(cyc + 2);
        launch(4, 3, 5, n);
        push_row(0, n + p);
        push_row(1, n + 2 * p);
        wait_until(n + 1);
        trigger_i = 1'b0;
        wait_until(n + 2 * p + 8);
        chk("mid_in_shs", SH_SIG, 1);
        chk("mid_row2", ROWADD_RO, 2);
        rst = 1'b1;
        wait_until(n + 2 * p + 9);
        check_all_zero("mid_rst");
        rst = 1'b0;
        wait_until(n + 2 * p + 14);
        chk("mid_idle_busy", re_busy, 0);
        chk("mid_idle_pixsel", PIXSEL, 0);

`ifdef RO_STALL_TIMEOUT_EN
        // Stall timeout: row 0 dropped after 65535 stalled cycles
        p = 17;
        fifo_ready = 1'b0;
        wait_until(cyc + 2);
        launch(4, 3, 5, n);
        for (int r = 1; r < int'(NR); r++) push_row(r, n + 70001 + (r - 1) * p);
        wait_until(n + 1);
        trigger_i = 1'b0;
        wait_until(n + p + 65533);
        chk("stall_no_ovf_yet", overflow, 0);
        wait_until(n + p + 65534);
        chk("stall_overflow", overflow, 1);
        wait_until(n + 70000);
        fifo_ready = 1'b1;
        wait_until(n + 70001 + 2 * p + 1);
        chk("stall_busy_fall", re_busy, 0);
        chk("stall_frame_cnt", frame_cnt, 1);
        chk("stall_overflow_sticky", overflow, 1);
`endif

        wait_until(cyc + 3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
